// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory access unit: request sizes, FSM states
// and the in-range byte address limit.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_MERGE_WR,
        ST_RESP
    } state_t;

    localparam int DM_WORDS = 1024;

    // First out-of-range byte address for a memory of the given depth.
    function automatic logic [32:0] byte_limit(input int words);
        return 33'(words) << 2;
    endfunction

    localparam logic [32:0] DM_BYTE_LIMIT = byte_limit(DM_WORDS);

endpackage

// File: rtl/dm_lane_align.sv
// Little-endian lane steering: extracts/extends sub-word load data and builds
// the merged word for sub-word read-modify-write stores.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] shifted;

    assign shamt   = {offset, 3'b000};
    assign shifted = word >> shamt;

    // Half accesses are only ever issued with offset[0]=0, so a shift of 0 or 16 suffices.
    always_comb begin
        load_data = word;
        merged    = word;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
                merged    = (word & ~(32'h0000_00ff << shamt)) | ({24'b0, wdata[7:0]} << shamt);
            end
            SZ_HALF: begin
                load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
                merged    = (word & ~(32'h0000_ffff << shamt)) | ({16'b0, wdata} << shamt);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// Load/store front-end for the word-addressed data memory: validates requests,
// drives the memory port and performs sub-word stores as read-modify-write.
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int WORDS = DM_WORDS,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_fault,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_read_en,
    output logic          mem_write_en,
    input  logic [31:0]   mem_rdata
);

    localparam logic [32:0] BYTE_LIMIT = byte_limit(WORDS);

    state_t        state;
    logic          write_q;
    logic [1:0]    size_q;
    logic          signed_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   merge_q;

    logic          req_fault;
    logic [31:0]   load_data;
    logic [31:0]   merged;

    assign req_ready = (state == ST_IDLE);

    always_comb begin
        req_fault = 1'b0;
        case (req_size)
            SZ_BYTE: req_fault = 1'b0;
            SZ_HALF: req_fault = req_addr[0];
            SZ_WORD: req_fault = (req_addr[1:0] != 2'b00);
            default: req_fault = 1'b1;
        endcase
        if ({1'b0, req_addr} >= BYTE_LIMIT) req_fault = 1'b1;
    end

    dm_lane_align u_lane_align (
        .word      (mem_rdata),
        .offset    (addr_q[1:0]),
        .size      (size_q),
        .is_signed (signed_q),
        .wdata     (wdata_q[15:0]),
        .load_data (load_data),
        .merged    (merged)
    );

    // NOTE: every register here is assigned with <= so all branches see the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'b0;
            merge_q    <= 32'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'b0;
            resp_fault <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        addr_q   <= req_addr[AW+1:0];
                        wdata_q  <= req_wdata;
                        if (req_fault) begin
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'b0;
                            state      <= ST_RESP;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!write_q) begin
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= load_data;
                        state      <= ST_RESP;
                    end else if (size_q == SZ_WORD) begin
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= 32'b0;
                        state      <= ST_RESP;
                    end else begin
                        merge_q <= merged;
                        state   <= ST_MERGE_WR;
                    end
                end
                ST_MERGE_WR: begin
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                    resp_rdata <= 32'b0;
                    state      <= ST_RESP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory port is decoded from state; the write strobe is suppressed while reset is high.
    always_comb begin
        mem_addr     = '0;
        mem_wdata    = 32'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        case (state)
            ST_ACCESS: begin
                mem_addr    = addr_q[AW+1:2];
                mem_read_en = 1'b1;
                if (write_q && size_q == SZ_WORD) begin
                    mem_write_en = 1'b1;
                    mem_wdata    = wdata_q;
                end
            end
            ST_MERGE_WR: begin
                mem_addr     = addr_q[AW+1:2];
                mem_write_en = 1'b1;
                mem_wdata    = merge_q;
            end
            default: ;
        endcase
        if (reset) mem_write_en = 1'b0;
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench for dm_access_unit with a behavioural 1024x32 data memory.
module tb_dm_access_unit;

    localparam int WORDS = 1024;
    localparam int AW    = 10;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_fault;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_read_en;
    logic          mem_write_en;
    logic [31:0]   mem_rdata;

    dm_access_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_rdata    (mem_rdata)
    );

    // Behavioural data memory: combinational gated read, synchronous clear on reset.
    logic [31:0] mem [WORDS];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= 32'b0;
        end else if (mem_write_en) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_read_en ? mem[mem_addr] : 32'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_writes = 0;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        fault;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Response monitor: pops the scoreboard on every response pulse.
    always @(negedge clk) begin
        if (mem_write_en) n_writes++;
        if (!reset && resp_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", resp_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.tag, "_rdata"}, resp_rdata, e.rdata);
                check({e.tag, "_fault"}, 32'(resp_fault), 32'(e.fault));
                check({e.tag, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_f, input int exp_lat, input bit keep, output int acc);
        int g = 0;
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        while (!req_ready && g < 10) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) begin
            check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        sb_q.push_back('{tag, exp_rd, exp_f, acc, exp_lat});
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while (sb_q.size() != 0 && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        check({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic op(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic exp_f, input int exp_lat);
        int acc;
        issue(tag, w, sz, sg, a, wd, exp_rd, exp_f, exp_lat, 1'b0, acc);
        drain(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc [4];
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'b0;
        req_wdata  = 32'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_fault", 32'(resp_fault), 32'd0);
        check("rst_mem_we", 32'(mem_write_en), 32'd0);
        check("rst_mem_re", 32'(mem_read_en), 32'd0);
        @(posedge clk);
        #1;

        // Word store then load.
        op("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        check("mem4_sw", mem[4], 32'hDEAD_BEEF);
        op("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

        // Byte store via read-modify-write, then byte loads.
        op("sb_12", 1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_005A, 32'h0, 1'b0, 3);
        check("mem4_sb", mem[4], 32'hDE5A_BEEF);
        op("lb_12", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'h0000_005A, 1'b0, 2);
        op("lb_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, 2);
        op("lbu_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, 2);

        // Half store, then half loads.
        op("sh_10", 1'b1, 2'b01, 1'b0, 32'h10, 32'h1234_8001, 32'h0, 1'b0, 3);
        check("mem4_sh", mem[4], 32'hDE5A_8001);
        op("lh_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'hFFFF_8001, 1'b0, 2);
        op("lhu_10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000_8001, 1'b0, 2);

        // Faulting requests: one-cycle latency, no memory write.
        n_writes = 0;
        op("lh_11_flt", 1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 32'h0, 1'b1, 1);
        op("sw_16_flt", 1'b1, 2'b10, 1'b0, 32'h16, 32'h1111_1111, 32'h0, 1'b1, 1);
        op("lw_1000_flt", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1);
        op("sz11_flt", 1'b1, 2'b11, 1'b0, 32'h10, 32'h2222_2222, 32'h0, 1'b1, 1);
        check("flt_no_writes", 32'(n_writes), 32'd0);
        check("mem4_after_flt", mem[4], 32'hDE5A_8001);

        // Back-to-back loads with req_valid held high.
        issue("st_lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDE5A_8001, 1'b0, 2, 1'b1, acc[0]);
        issue("st_lbu_11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000_0080, 1'b0, 2, 1'b1, acc[1]);
        issue("st_lh_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF_DE5A, 1'b0, 2, 1'b1, acc[2]);
        issue("st_lb_10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h0000_0001, 1'b0, 2, 1'b0, acc[3]);
        drain("stream");
        for (int i = 1; i < 4; i++) check($sformatf("stream_gap%0d", i), 32'(acc[i] - acc[i-1]), 32'd3);

        // Reset asserted while a byte store sits in MERGE_WR.
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h20;
        req_wdata = 32'h0000_0077;
        @(negedge clk);
        check("rst_sb_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_sb_merge_we", 32'(mem_write_en), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_sb_we_blocked", 32'(mem_write_en), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_sb_ready_after", 32'(req_ready), 32'd1);
        check("rst_sb_no_resp", 32'(resp_valid), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        op("lw_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 2);

        repeat (2) @(posedge clk);
        check("final_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
